// File: rtl/hnf_txdat_beat_seq_pkg.sv
// Shared types and constants for the HN-F TXDAT beat sequencer and its credit counter.
// CHI-E field widths are collected here so every file sizes its ports the same way.
package hnf_txdat_beat_seq_pkg;

   localparam int CHIE_DATA_WIDTH       = 256;
   localparam int CHIE_BE_WIDTH         = 32;
   localparam int CHIE_NODEID_WIDTH     = 11;
   localparam int CHIE_TXNID_WIDTH      = 12;
   localparam int CHIE_DAT_OPCODE_WIDTH = 4;
   localparam int CHIE_RESP_WIDTH       = 3;
   localparam int CHIE_DBID_WIDTH       = 12;
   localparam int CHIE_DATAID_WIDTH     = 2;
   localparam int MSHR_ENTRIES_WIDTH    = 4;

   localparam int LCRD_MAX_DEFAULT = 15;
   localparam int LCRD_CNT_WIDTH   = 4;

   localparam logic [CHIE_DATAID_WIDTH-1:0] DATAID_BEAT0 = 2'b00;
   localparam logic [CHIE_DATAID_WIDTH-1:0] DATAID_BEAT1 = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } txdat_state_e;

   // An empty presence mask still means "send the whole line".
   function automatic logic [1:0] pend_from_pe(input logic [1:0] pe);
      return (pe == 2'b00) ? 2'b11 : pe;
   endfunction

endpackage

// File: rtl/hnf_lcrd_cnt.sv
// Saturating up/down link-credit counter; flags a credit returned while already full.
// Shared by the TXDAT sequencer and the RXREQ/TXRSP link logic.
module hnf_lcrd_cnt #(
   parameter int MAX = 15,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         ovf
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   // A simultaneous return and spend cancel out, so only a lone return can overflow.
   assign ovf = inc && !dec && (cnt == MAX_V);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (inc && !dec && (cnt != MAX_V)) begin
         cnt <= cnt + W'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/hnf_txdat_beat_seq.sv
// Latches one 64 B line from the data buffer and emits its present 32 B halves as
// CHI-E DAT flits (DataID 00 then 10), one per cycle while link credit is available.
module hnf_txdat_beat_seq
   import hnf_txdat_beat_seq_pkg::*;
#(
   parameter logic [CHIE_NODEID_WIDTH-1:0] HNF_NID  = '0,
   parameter int                           LCRD_MAX = LCRD_MAX_DEFAULT
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               dbf_txdat_valid_sx1,
   input  logic [MSHR_ENTRIES_WIDTH-1:0]      dbf_txdat_idx_sx1,
   input  logic [2*CHIE_BE_WIDTH-1:0]         dbf_txdat_be_sx1,
   input  logic [2*CHIE_DATA_WIDTH-1:0]       dbf_txdat_data_sx1,
   input  logic [1:0]                         dbf_txdat_pe_sx1,
   input  logic [CHIE_NODEID_WIDTH-1:0]       mshr_txdat_tgtid_sx1,
   input  logic [CHIE_TXNID_WIDTH-1:0]        mshr_txdat_txnid_sx1,
   input  logic [CHIE_DAT_OPCODE_WIDTH-1:0]   mshr_txdat_opcode_sx1,
   input  logic [CHIE_RESP_WIDTH-1:0]         mshr_txdat_resp_sx1,
   input  logic                               txdat_lcrdv,
   output logic                               txdat_dbf_busy,
   output logic                               txdat_flitv_q,
   output logic [CHIE_NODEID_WIDTH-1:0]       txdat_flit_tgtid_q,
   output logic [CHIE_NODEID_WIDTH-1:0]       txdat_flit_srcid_q,
   output logic [CHIE_TXNID_WIDTH-1:0]        txdat_flit_txnid_q,
   output logic [CHIE_DAT_OPCODE_WIDTH-1:0]   txdat_flit_opcode_q,
   output logic [CHIE_RESP_WIDTH-1:0]         txdat_flit_resp_q,
   output logic [CHIE_DBID_WIDTH-1:0]         txdat_flit_dbid_q,
   output logic [CHIE_DATAID_WIDTH-1:0]       txdat_flit_dataid_q,
   output logic [CHIE_BE_WIDTH-1:0]           txdat_flit_be_q,
   output logic [CHIE_DATA_WIDTH-1:0]         txdat_flit_data_q,
   output logic                               txdat_err_q
);

   txdat_state_e                       state;
   logic [1:0]                         pend_p1;
   logic [2*CHIE_DATA_WIDTH-1:0]       data_p1;
   logic [2*CHIE_BE_WIDTH-1:0]         be_p1;
   logic [MSHR_ENTRIES_WIDTH-1:0]      idx_p1;
   logic [CHIE_NODEID_WIDTH-1:0]       tgtid_p1;
   logic [CHIE_TXNID_WIDTH-1:0]        txnid_p1;
   logic [CHIE_DAT_OPCODE_WIDTH-1:0]   opcode_p1;
   logic [CHIE_RESP_WIDTH-1:0]         resp_p1;

   logic [LCRD_CNT_WIDTH-1:0] credit;
   logic                      credit_ovf;
   logic                      credit_ok;
   logic                      send;
   logic                      beat_hi;
   logic                      last_pend;
   logic                      accept;
   logic                      drop;
   logic [1:0]                pend_after;

   hnf_lcrd_cnt #(
      .MAX (LCRD_MAX),
      .W   (LCRD_CNT_WIDTH)
   ) u_lcrd_cnt (
      .clk (clk),
      .rst (rst),
      .inc (txdat_lcrdv),
      .dec (send),
      .cnt (credit),
      .ovf (credit_ovf)
   );

   assign credit_ok  = (credit != '0);
   assign send       = (state == ST_SEND) && credit_ok;
   assign beat_hi    = !pend_p1[0];
   assign pend_after = beat_hi ? (pend_p1 & 2'b01) : (pend_p1 & 2'b10);
   assign last_pend  = (pend_p1 == 2'b01) || (pend_p1 == 2'b10);

   // Busy drops in the cycle the final beat is guaranteed to leave, so a new line can
   // be strobed back-to-back without a bubble.
   assign txdat_dbf_busy = (state == ST_SEND) && !(last_pend && credit_ok);
   assign accept         = dbf_txdat_valid_sx1 && !txdat_dbf_busy;
   assign drop           = dbf_txdat_valid_sx1 && txdat_dbf_busy;

   // ---- stage p1: line register (data path, no reset) ----
   always_ff @(posedge clk) begin
      if (accept) begin
         data_p1   <= dbf_txdat_data_sx1;
         be_p1     <= dbf_txdat_be_sx1;
         idx_p1    <= dbf_txdat_idx_sx1;
         tgtid_p1  <= mshr_txdat_tgtid_sx1;
         txnid_p1  <= mshr_txdat_txnid_sx1;
         opcode_p1 <= mshr_txdat_opcode_sx1;
         resp_p1   <= mshr_txdat_resp_sx1;
      end
   end

   // ---- stage q: sequencing FSM and registered flit ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         state               <= ST_IDLE;
         pend_p1             <= 2'b00;
         txdat_flitv_q       <= 1'b0;
         txdat_flit_tgtid_q  <= '0;
         txdat_flit_srcid_q  <= '0;
         txdat_flit_txnid_q  <= '0;
         txdat_flit_opcode_q <= '0;
         txdat_flit_resp_q   <= '0;
         txdat_flit_dbid_q   <= '0;
         txdat_flit_dataid_q <= '0;
         txdat_flit_be_q     <= '0;
         txdat_flit_data_q   <= '0;
         txdat_err_q         <= 1'b0;
      end else begin
         txdat_flitv_q <= send;
         txdat_err_q   <= txdat_err_q | drop | credit_ovf;

         if (send) begin
            txdat_flit_tgtid_q  <= tgtid_p1;
            txdat_flit_srcid_q  <= HNF_NID;
            txdat_flit_txnid_q  <= txnid_p1;
            txdat_flit_opcode_q <= opcode_p1;
            txdat_flit_resp_q   <= resp_p1;
            txdat_flit_dbid_q   <= CHIE_DBID_WIDTH'(idx_p1);
            txdat_flit_dataid_q <= beat_hi ? DATAID_BEAT1 : DATAID_BEAT0;
            txdat_flit_be_q     <= beat_hi ? be_p1[2*CHIE_BE_WIDTH-1:CHIE_BE_WIDTH]
                                           : be_p1[CHIE_BE_WIDTH-1:0];
            txdat_flit_data_q   <= beat_hi ? data_p1[2*CHIE_DATA_WIDTH-1:CHIE_DATA_WIDTH]
                                           : data_p1[CHIE_DATA_WIDTH-1:0];
         end

         // Accept in SEND only happens alongside the final beat, so it overrides the clear.
         if (accept) begin
            pend_p1 <= pend_from_pe(dbf_txdat_pe_sx1);
            state   <= ST_SEND;
         end else if (send) begin
            pend_p1 <= pend_after;
            if (pend_after == 2'b00) begin
               state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: doc/hnf_txdat_beat_seq.md
# hnf_txdat_beat_seq

Serialises one 64-byte line read from the HN-F data buffer into one or two CHI-E DAT flits for the TXDAT link. It sits directly downstream of the data buffer's TX read port and upstream of the TXDAT link wrapper. The block:
- latches the line, its byte enables and its per-half presence bits in the same cycle as the MSHR read strobe;
- emits the present halves as DataID 2'b00 then 2'b10, gated by a local link-credit counter;
- back-pressures the MSHR with a busy signal.

## Interface
Parameters:
- HNF_NID, 0: SrcID driven on every flit.
- LCRD_MAX, 15: maximum link credits held; the counter is 4 bits wide.

Ports (clock and reset first). Widths use the `CHIE_*` and `MSHR_ENTRIES_WIDTH` macros.
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-low.
- dbf_txdat_valid_sx1  in  1  line read strobe from the data buffer.
- dbf_txdat_idx_sx1  in  MSHR_ENTRIES_WIDTH  MSHR index; drives DBID.
- dbf_txdat_be_sx1  in  2*BE_WIDTH  line byte enables.
- dbf_txdat_data_sx1  in  2*DATA_WIDTH  line data.
- dbf_txdat_pe_sx1  in  2  half present: bit0 = low 32 B, bit1 = high 32 B.
- mshr_txdat_tgtid_sx1  in  NODEID_WIDTH  destination node.
- mshr_txdat_txnid_sx1  in  TXNID_WIDTH  TxnID to return.
- mshr_txdat_opcode_sx1  in  DAT_OPCODE_WIDTH  for example CompData.
- mshr_txdat_resp_sx1  in  RESP_WIDTH  Resp field.
- txdat_lcrdv  in  1  one link credit returned per cycle high.
- txdat_dbf_busy  out  1  combinational; the MSHR must not strobe while it is high.
- txdat_flitv_q  out  1  flit valid, registered.
- txdat_flit_{tgtid,srcid,txnid,opcode,resp,dbid,dataid,be,data}_q  out  per field  registered flit fields.
- txdat_err_q  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, SEND.
- Line register holds: data, be, metadata, idx, and pend[1:0]. pend = pe, except pe==2'b00 loads 2'b11 (full-line send with the stored BE, which may be zero).
- Accept: strobe while not busy. The line register is loaded, pend is set, and state goes to SEND.
- Strobe while busy: the strobe is ignored, the line is dropped, and txdat_err_q is set.
- SEND, one beat per cycle when credit count > 0:
  - Beat selected is the lowest set pend bit. Beat 0 uses low halves and DataID 2'b00. Beat 1 uses high halves and DataID 2'b10.
  - The flit registers are loaded, flitv is set for one cycle, and the selected pend bit is cleared.
- Leaving SEND: when the last pend bit clears, go to IDLE. If a strobe arrives in that same cycle, accept it and stay in SEND (back-to-back lines).
- Busy: txdat_dbf_busy = (state==SEND) && !(exactly one pend bit set && credit > 0).
- Credit counter:
  - +1 on lcrdv and −1 on a flit sent; both in one cycle leaves it unchanged.
  - lcrdv at LCRD_MAX with no flit sent saturates the counter and sets txdat_err_q.
  - The counter never underflows, because a beat is only sent when the count is > 0.
- Field mapping: SrcID = HNF_NID; DBID = idx zero-extended; all other fields are copied from the latched metadata.

## Timing
- Reset (rst low at a clock edge):
  - state IDLE, pend 0, credit 0;
  - txdat_flitv_q 0, all flit fields 0, txdat_err_q 0;
  - txdat_dbf_busy therefore 0.
- Reset mid-line drops the line without emitting further beats.
- Latency: strobe in cycle N gives the first flitv in cycle N+2 (with credit available in N+1), and the second beat in N+3.
- Credit starvation: beats stall in SEND with flitv low; the line register is held unchanged.
- A credit returned in cycle N can be spent no earlier than cycle N+1.
- Throughput: one flit per cycle sustained with back-to-back lines and adequate credit.

## Structure
- Shared package/defines: state encoding, DataID constants (2'b00, 2'b10), and LCRD_MAX default. Field widths already come from `CHIE_*`.
- One natural sub-module, hnf_lcrd_cnt: the saturating up/down credit counter with overflow flag. It is reusable by the RXREQ/TXRSP link logic.

## Test plan
- Give 2 credits, strobe with pe=11, idx=5. Expect flits in N+2 and N+3: DataID 00 with the low data, then 10 with the high data, DBID=5. Credit count ends at 0.
- Give 1 credit, strobe with pe=11. Expect one flit, then flitv held low. Return a credit in cycle M and expect the second flit in M+2. busy stays high until the last-beat cycle.
- pe=10 gives a single flit with DataID 10 and the high halves. pe=00 gives two flits with BE equal to the stored (zero) byte enables.
- With 4 credits, strobe line A (pe=11) and strobe line B in the cycle A's beat 1 is sent. Expect 4 consecutive flitv cycles, A0 A1 B0 B1, and no error.
- Strobe while busy: expect txdat_err_q=1, the second line never emitted, and the first line completing intact.
- Drive 16 lcrdv pulses with no sends: count saturates at 15 and txdat_err_q=1. Pull rst low mid-SEND: next cycle flitv=0, busy=0, credit=0, err=0.
